// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and the baud-tick divisor calculation.
package uart_pkg;

  // Receiver states, from line idle through stop-bit validation and break recovery
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Each bit period is split into this many oversample ticks
  localparam int OVERSAMPLE  = 16;
  // Oversample index at the middle of the start bit, counted from the falling edge
  localparam int MID_SAMPLE  = 7;
  // Oversample index one full bit after the previous mid-bit sample
  localparam int LAST_SAMPLE = 15;
  // 8N1 framing: eight data bits per character
  localparam int DATA_BITS   = 8;

  // Clock cycles per oversample tick, rounded down
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return clk_freq / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with occupancy output. A pop is honoured only when
// the FIFO holds data. A push into a full FIFO is accepted only when a pop
// happens in the same cycle. Otherwise the push is dropped and the contents
// stay unchanged. The head word is presented combinationally and reads as zero
// when the FIFO is empty.
module uart_rx_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   level
);

  localparam int PTR_W = $clog2(depth);
  localparam int LVL_W = PTR_W + 1;

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Advance pointers and occupancy for the accepted push/pop combination
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers, emptied on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array written at the tail. Entries need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver. The asynchronous line passes through a two-flop
// synchronizer. The receiver oversamples the line at 16x the baud rate,
// validates the start bit at its midpoint, and shifts in the data bits
// LSB first. The stop bit is then checked. Good characters are queued in a
// small FIFO for a bus-side consumer. Sticky flags report stop-bit errors and
// characters lost to a full FIFO.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200,
  parameter int fifo_depth     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_avail,
  input  logic                          rx_ack,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(fifo_depth):0]   rx_level
);

  localparam int DIVISOR = calc_divisor(clk_freq, uart_baud_rate);
  localparam int TICK_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS) + 1;

  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_rx_sampler: clk_freq too low for 16x oversampling at uart_baud_rate");
  end

  if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_sampler: fifo_depth must be a power of two and at least 2");
  end

  // Synchronizer and synchronized line
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rxd;

  // Baud tick and oversample timing
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [3:0]        os_cnt_q, os_cnt_d;
  logic              mid_tick;
  logic              last_tick;

  // Character assembly
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;

  // Sticky status
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  // FSM and its decoded controls
  rx_state_t state_q, state_d;
  logic      timing_clr;
  logic      bit_start;
  logic      shift_en;
  logic      byte_done;
  logic      stop_bad;

  // FIFO interface
  logic [DATA_BITS-1:0]          fifo_dout;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic [$clog2(fifo_depth):0]   fifo_level;
  logic                          pop;
  logic                          overrun_evt;

  assign rxd       = sync2_q;
  assign tick      = (tick_cnt_q == TICK_W'(DIVISOR - 1));
  assign mid_tick  = tick && (os_cnt_q == 4'(MID_SAMPLE));
  assign last_tick = tick && (os_cnt_q == 4'(LAST_SAMPLE));

  // Two-stage synchronizer feeding all line decisions
  always_comb begin
    sync1_d = uart_rxd;
    sync2_d = sync1_q;
  end

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: frame progression and recovery from false starts or breaks
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rxd) begin
          state_d = START;
        end
      end
      START: begin
        if (mid_tick) begin
          state_d = rxd ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_tick && (bit_cnt_q == BIT_W'(DATA_BITS - 1))) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          state_d = rxd ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: per-state control strobes for the timing and datapath logic
  always_comb begin
    timing_clr = 1'b0;
    bit_start  = 1'b0;
    shift_en   = 1'b0;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      IDLE:    timing_clr = !rxd;
      START:   bit_start  = mid_tick && !rxd;
      DATA:    shift_en   = last_tick;
      STOP: begin
        byte_done = last_tick && rxd;
        stop_bad  = last_tick && !rxd;
      end
      default: ;
    endcase
  end

  assign pop         = rx_ack && rx_avail;
  assign overrun_evt = push_q && fifo_full && !pop;

  // Timing counters, bit assembly and sticky flags; a flag set beats a same-cycle clear
  always_comb begin
    if (timing_clr || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    if (timing_clr || bit_start) begin
      os_cnt_d = '0;
    end else if (tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
    end else begin
      os_cnt_d = os_cnt_q;
    end

    if (bit_start) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (shift_en) begin
      shift_d = {rxd, shift_q[DATA_BITS-1:1]};
    end else begin
      shift_d = shift_q;
    end

    push_d = byte_done;

    if (stop_bad) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end

    if (overrun_evt) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Datapath registers; reset abandons any partially received character
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // The shift register holds the completed character through the following cycle, which is when it is pushed
  uart_rx_fifo #(
    .width (DATA_BITS),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign rx_data   = fifo_dout;
  assign rx_avail  = !fifo_empty;
  assign rx_level  = fifo_level;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serial frames are driven onto the line and the
// FIFO, flags and timing are compared against expectations worked out from
// bit-period arithmetic and a queue-based model of the receive buffer.
module tb_uart_rx_sampler;

  localparam int CLK_FREQ = 6400000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_FREQ / (16 * BAUD);
  localparam int BIT_CLKS = 16 * DIV;
  // Clock edges from the start edge to the push: 2 to synchronize, 1 to detect,
  // 8 ticks to reach mid start bit, then 9 bit periods (8 data + stop), then 1 to push.
  localparam int PUSH_EDGE = 2 + 1 + 8 * DIV + 9 * BIT_CLKS + 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ack   = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       frame_err;
  logic       overrun;
  logic [3:0] rx_level;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       stop_bit;
    logic       clr_after;
    logic [3:0] exp_level;
    logic       exp_avail;
    logic [7:0] exp_head;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t       vecs [3];
  logic [7:0] fill_bytes [8];
  logic [7:0] model_q [$];
  logic       model_fe;
  logic       model_ov;
  logic [7:0] rnd_data;
  logic       rnd_good;
  int         rnd_pops;
  int         lat;

  uart_rx_sampler #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD),
    .fifo_depth     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_level  (rx_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge; a 0 stop bit is held low for extra clocks
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int low_hold);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    if (!stop_bit) repeat (low_hold) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic popByte(input string name, input logic [7:0] expected);
    checkOutput(name, 32'(rx_data), 32'(expected));
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    vecs[0] = '{data: 8'h3C, stop_bit: 1'b0, clr_after: 1'b0, exp_level: 4'd1, exp_avail: 1'b1, exp_head: 8'hA5, exp_fe: 1'b1, exp_ov: 1'b0};
    vecs[1] = '{data: 8'h81, stop_bit: 1'b1, clr_after: 1'b1, exp_level: 4'd2, exp_avail: 1'b1, exp_head: 8'hA5, exp_fe: 1'b0, exp_ov: 1'b0};
    vecs[2] = '{data: 8'hE7, stop_bit: 1'b1, clr_after: 1'b0, exp_level: 4'd3, exp_avail: 1'b1, exp_head: 8'hA5, exp_fe: 1'b0, exp_ov: 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_data",  32'(rx_data),   32'h0);
    checkOutput("rst_avail", 32'(rx_avail),  32'h0);
    checkOutput("rst_fe",    32'(frame_err), 32'h0);
    checkOutput("rst_ov",    32'(overrun),   32'h0);
    checkOutput("rst_level", 32'(rx_level),  32'h0);

    $display("[TB] first byte and availability latency");
    lat = 0;
    fork
      applyStimulus(8'hA5, 1'b1, 0);
      begin
        while (lat < 800) begin
          @(negedge clk);
          lat++;
          if (rx_avail) break;
        end
      end
    join
    checkOutput("avail_latency", 32'(lat),       32'(PUSH_EDGE));
    checkOutput("a5_data",       32'(rx_data),   32'hA5);
    checkOutput("a5_level",      32'(rx_level),  32'd1);
    checkOutput("a5_fe",         32'(frame_err), 32'h0);

    $display("[TB] vector table");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stop_bit, 200);
      if (vecs[i].clr_after) pulseErrClr();
      repeat (4) @(negedge clk);
      checkOutput($sformatf("vec%0d_level", i), 32'(rx_level),  32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d_avail", i), 32'(rx_avail),  32'(vecs[i].exp_avail));
      checkOutput($sformatf("vec%0d_head", i),  32'(rx_data),   32'(vecs[i].exp_head));
      checkOutput($sformatf("vec%0d_fe", i),    32'(frame_err), 32'(vecs[i].exp_fe));
      checkOutput($sformatf("vec%0d_ov", i),    32'(overrun),   32'(vecs[i].exp_ov));
    end
    popByte("drain_0", 8'hA5);
    popByte("drain_1", 8'h81);
    popByte("drain_2", 8'hE7);
    checkOutput("drain_level", 32'(rx_level), 32'd0);
    checkOutput("drain_avail", 32'(rx_avail), 32'd0);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    checkOutput("ack_empty_level", 32'(rx_level), 32'd0);
    checkOutput("ack_empty_data",  32'(rx_data),  32'h0);

    $display("[TB] glitch on idle line");
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitch_avail", 32'(rx_avail),  32'd0);
    checkOutput("glitch_level", 32'(rx_level),  32'd0);
    checkOutput("glitch_fe",    32'(frame_err), 32'd0);
    checkOutput("glitch_ov",    32'(overrun),   32'd0);

    $display("[TB] framing error coinciding with clear");
    fork
      applyStimulus(8'hC3, 1'b0, 200);
      begin
        repeat (PUSH_EDGE - 2) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
      end
    join
    checkOutput("setwins_fe",    32'(frame_err), 32'd1);
    checkOutput("setwins_avail", 32'(rx_avail),  32'd0);
    pulseErrClr();
    checkOutput("clr_fe", 32'(frame_err), 32'd0);

    $display("[TB] overrun with nine bytes");
    for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, 0);
    checkOutput("ovr_level", 32'(rx_level), 32'd8);
    checkOutput("ovr_flag",  32'(overrun),  32'd1);
    for (int i = 0; i < 8; i++) popByte($sformatf("ovr_pop%0d", i), 8'(i));
    checkOutput("ovr_empty", 32'(rx_avail), 32'd0);
    pulseErrClr();
    checkOutput("ovr_clr", 32'(overrun), 32'd0);

    $display("[TB] pop coinciding with push into full FIFO");
    for (int i = 0; i < 8; i++) begin
      fill_bytes[i] = 8'($urandom);
      applyStimulus(fill_bytes[i], 1'b1, 0);
    end
    checkOutput("full_level", 32'(rx_level), 32'd8);
    fork
      applyStimulus(8'h55, 1'b1, 0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("same_cycle_head", 32'(rx_data), 32'(fill_bytes[0]));
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    checkOutput("same_cycle_ov",    32'(overrun),  32'd0);
    checkOutput("same_cycle_level", 32'(rx_level), 32'd8);
    for (int i = 1; i < 8; i++) popByte($sformatf("same_cycle_pop%0d", i), fill_bytes[i]);
    popByte("same_cycle_last", 8'h55);
    checkOutput("same_cycle_empty", 32'(rx_level), 32'd0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h5E, 1'b0, 200);
    checkOutput("pre_rst_level", 32'(rx_level),  32'd1);
    checkOutput("pre_rst_fe",    32'(frame_err), 32'd1);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = rnd_data_bit(8'h96, i);
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = rnd_data_bit(8'h96, 4);
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_data",  32'(rx_data),   32'h0);
    checkOutput("midrst_avail", 32'(rx_avail),  32'h0);
    checkOutput("midrst_fe",    32'(frame_err), 32'h0);
    checkOutput("midrst_ov",    32'(overrun),   32'h0);
    checkOutput("midrst_level", 32'(rx_level),  32'h0);
    repeat (200) @(negedge clk);
    applyStimulus(8'h42, 1'b1, 0);
    checkOutput("post_rst_level", 32'(rx_level),  32'd1);
    checkOutput("post_rst_fe",    32'(frame_err), 32'd0);
    popByte("post_rst_data", 8'h42);

    $display("[TB] randomized frames against the buffer model");
    model_q.delete();
    model_fe = 1'b0;
    model_ov = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulseErrClr();
        model_fe = 1'b0;
        model_ov = 1'b0;
      end
      rnd_data = 8'($urandom);
      rnd_good = ($urandom_range(0, 7) != 0);
      applyStimulus(rnd_data, rnd_good, 150);
      if (!rnd_good) model_fe = 1'b1;
      else if (model_q.size() < DEPTH) model_q.push_back(rnd_data);
      else model_ov = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput($sformatf("rnd%0d_level", n), 32'(rx_level),  32'(model_q.size()));
      checkOutput($sformatf("rnd%0d_avail", n), 32'(rx_avail),  32'(model_q.size() != 0));
      checkOutput($sformatf("rnd%0d_fe", n),    32'(frame_err), 32'(model_fe));
      checkOutput($sformatf("rnd%0d_ov", n),    32'(overrun),   32'(model_ov));
      checkOutput($sformatf("rnd%0d_head", n),  32'(rx_data),   32'((model_q.size() != 0) ? model_q[0] : 8'h00));
      rnd_pops = $urandom_range(0, 2);
      for (int k = 0; k < rnd_pops; k++) begin
        if (model_q.size() != 0) begin
          popByte($sformatf("rnd%0d_pop%0d", n, k), model_q.pop_front());
        end else begin
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
          @(negedge clk);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic rnd_data_bit(input logic [7:0] value, input int idx);
    logic [7:0] v;
    v = value;
    return v[idx];
  endfunction

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Synthesizable UART receiver at the far end of the system's uart_txd line; the same block serves as the bench-side comm partner and as the on-chip RX path.
- Oversamples the serial input at 16x baud, validates start and stop bits, and assembles 8N1 bytes LSB-first.
- Buffers received bytes in a small FIFO that a bus-side consumer drains via a valid/ack handshake; sticky framing and overrun flags report errors.

Parameters:
clk_freq, 50000000, system clock frequency in Hz
uart_baud_rate, 115200, line bit rate
fifo_depth, 8, receive FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
uart_rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  byte at FIFO head, valid while rx_avail=1
rx_avail  output  1  FIFO non-empty
rx_ack  input  1  pop FIFO head this cycle; ignored when rx_avail=0
err_clr  input  1  clear sticky frame_err and overrun
frame_err  output  1  sticky: stop bit sampled 0
overrun  output  1  sticky: byte completed while FIFO full, byte dropped
rx_level  output  $clog2(fifo_depth)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): rx_data=0, rx_avail=0, frame_err=0, overrun=0, rx_level=0; synchronizer flops=1; FSM=IDLE; all counters=0.
- Input sync: 2-FF synchronizer on uart_rxd, giving 2 cycles of latency; all decisions use the synchronized value.
- Tick generator:
  - divisor = clk_freq/(16*uart_baud_rate), integer division; elaboration error if divisor<1.
  - Free-running counter 0..divisor-1; tick pulses one cycle when counter==divisor-1.
- Oversample counter os_cnt is 4 bits and wraps 15->0.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: on synchronized rxd=0, clear os_cnt and the tick counter, go to START.
  - START: on the tick with os_cnt==7 (mid start bit), if rxd=1 it is a false start, go to IDLE with no flag. If rxd=0, clear os_cnt, clear bit_cnt, go to DATA.
  - DATA: on each tick with os_cnt==15, shift rxd into bit 7 of the shift register (right shift, LSB first) and increment bit_cnt. After the 8th bit go to STOP.
  - STOP: on the tick with os_cnt==15 (mid stop bit):
    - rxd=1: push the byte, then go to IDLE.
    - rxd=0: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd=1, then go to IDLE (covers break conditions).
- FIFO:
  - Push occurs in the cycle after the mid-stop-bit tick; rx_avail rises 1 cycle after the push.
  - Push while full (and no same-cycle pop) sets overrun and drops the byte; FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, level unchanged.
  - Push and pop in the same cycle while empty: only the push happens, since rx_avail=0 gates the pop.
  - Pointers wrap modulo fifo_depth. rx_data shows the head combinationally from FIFO storage and is undefined-free (0) when empty.
- Flags: err_clr clears both flags. If a set event and err_clr coincide, set wins.
- Reset mid-frame aborts the partial byte, empties the FIFO and clears flags. The first falling edge after release starts a new frame.
- Timing tolerance: sampling at mid-bit ±1 oversample tick, which accepts ±3% baud mismatch.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15, DATA_BITS=8
  - function calc_divisor(clk_freq, baud)
- Sub-module uart_rx_fifo: synchronous FIFO with parameters width and depth; ports push, pop, din, dout, empty, full, level. Shared with a later TX path.

Test Plan:
- Common setup: clk_freq=6400000, uart_baud_rate=100000, which gives divisor=4 and 64 clk per bit.
- Send 0xA5 8N1, rx_ack held 0 -> rx_avail=1 about 610 clk after the start edge; rx_data=0xA5, rx_level=1, frame_err=0.
- Drive a 20-clk low glitch on idle line -> FSM returns to IDLE, rx_avail stays 0, no flags set.
- Send 0x3C with stop bit forced 0, hold line low for 200 clk, then release -> frame_err=1, rx_avail=0. A following 0x81 is received correctly; pulsing err_clr then gives frame_err=0.
- Send 9 bytes 0x00..0x08 with no ack (fifo_depth=8) -> rx_level=8, overrun=1, popped sequence is 0x00..0x07, 0x08 lost.
- FIFO full, then pulse rx_ack in the exact cycle the 9th byte 0x55 pushes -> overrun=0, rx_level=8, last popped byte=0x55.
- Assert rst mid-bit 4 of 0x96, release after 3 clk -> all outputs 0; the next frame 0x42 is received intact.
